// File: rtl/hazard_pkg.sv
// hazard_pkg: scoreboard slot type, bubble constant and register-address width
package hazard_pkg;
    localparam int SB_AW = 4;
    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic [SB_AW-1:0] dest;
    } slot_t;
    localparam slot_t BUBBLE = '0;
endpackage

// File: rtl/hazard_src_match.sv
// hazard_src_match: one source operand against every qualifying scoreboard slot
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic [SB_AW-1:0]  src,
    input  logic              used,
    input  slot_t [DEPTH-1:0] slots,
    input  logic [DEPTH-1:0]  mask,
    output logic              match
);
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            match = match | (used && mask[i] && slots[i].valid && slots[i].wb_en && slots[i].dest == src);
    end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage data-hazard detector over in-flight destinations
// HAZARD_FORWARDING_EN: only loads younger than LOAD_LAT stall; otherwise any non-WB writer stalls
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = SB_AW,
    parameter int NUM_SRC  = 3,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic                      id_wb_en,
    input  logic                      id_mem_r_en,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      flush,
    input  logic                      freeze,
    output logic                      hazard,
    output logic [CNT_W-1:0]          stall_cnt
);
    slot_t [DEPTH-1:0] slots;
    logic [DEPTH-1:0]  mask;
    logic [NUM_SRC-1:0] match;
    slot_t             ins;

    if (LOAD_LAT < 1 || LOAD_LAT > DEPTH || DEPTH < 2 || REG_AW != SB_AW) begin : g_bad_cfg
        $error("hazard_scoreboard: unsupported parameter combination");
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_mask
`ifdef HAZARD_FORWARDING_EN
        assign mask[i] = (i < LOAD_LAT - 1) && slots[i].mem_r_en;
`else
        assign mask[i] = i < DEPTH - 1;
`endif
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        hazard_src_match #(.DEPTH(DEPTH)) u_match (
            .src   (id_src[k*REG_AW +: REG_AW]),
            .used  (id_src_used[k]),
            .slots (slots),
            .mask  (mask),
            .match (match[k])
        );
    end

    assign hazard = id_valid && |match;
    // flush outranks a stall: a squashed instruction never enters EXE
    assign ins = (id_valid && !hazard && !flush) ? slot_t'{1'b1, id_wb_en, id_mem_r_en, id_dest} : BUBBLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            slots     <= {DEPTH{BUBBLE}};
            stall_cnt <= '0;
        end else if (!freeze) begin
            slots <= {slots[DEPTH-2:0], ins};
            if (hazard && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: randomized and directed scoreboard bench against an in-flight list model
module tb_hazard_scoreboard;
    localparam int DEPTH = 3;
    localparam int LOAD_LAT = 2;
`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic id_valid = 1'b0;
    logic [11:0] id_src = '0;
    logic [2:0] id_src_used = '0;
    logic id_wb_en = 1'b0;
    logic id_mem_r_en = 1'b0;
    logic [3:0] id_dest = '0;
    logic flush = 1'b0;
    logic freeze = 1'b0;
    logic hazard, hazard4;
    logic [15:0] stall_cnt;
    logic [3:0] stall_cnt4;

    always #5 clk = ~clk;

    hazard_scoreboard #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .flush(flush),
        .freeze(freeze), .hazard(hazard), .stall_cnt(stall_cnt));

    hazard_scoreboard #(.DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src), .id_src_used(id_src_used),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .flush(flush),
        .freeze(freeze), .hazard(hazard4), .stall_cnt(stall_cnt4));

    typedef struct {
        logic wb;
        logic ld;
        logic [3:0] d;
        int age;
    } inst_t;
    typedef struct {
        logic h;
        logic [15:0] c;
        logic [3:0] c4;
    } exp_t;

    inst_t inflight[$];
    exp_t expq[$];
    int cnt_m = 0;
    int checks = 0;
    int failures = 0;
    logic last_h;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_haz();
        if (!id_valid) return 1'b0;
        foreach (inflight[j]) begin
            for (int k = 0; k < 3; k++) begin
                logic [3:0] s;
                s = id_src[k*4 +: 4];
                if (id_src_used[k] && inflight[j].wb && inflight[j].d == s &&
                    (FWD ? (inflight[j].ld && inflight[j].age < LOAD_LAT - 1) : (inflight[j].age < DEPTH - 1)))
                    return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic step();
        exp_t e;
        logic h;
        inst_t nq[$];
        h = m_haz();
        e.h = h;
        e.c = 16'(cnt_m > 65535 ? 65535 : cnt_m);
        e.c4 = 4'(cnt_m > 15 ? 15 : cnt_m);
        expq.push_back(e);
        @(negedge clk);
        last_h = hazard;
        @(posedge clk);
        if (rst) begin
            inflight.delete();
            cnt_m = 0;
        end else if (!freeze) begin
            if (h) cnt_m++;
            foreach (inflight[j])
                if (inflight[j].age + 1 < DEPTH) nq.push_back('{inflight[j].wb, inflight[j].ld, inflight[j].d, inflight[j].age + 1});
            if (id_valid && !h && !flush) nq.push_front('{id_wb_en, id_mem_r_en, id_dest, 0});
            inflight = nq;
        end
        #1;
    endtask

    task automatic set_inst(input logic v, input logic wb, input logic ld, input logic [3:0] d,
                            input logic [3:0] s0, input logic [3:0] s1, input logic [2:0] used);
        id_valid = v; id_wb_en = wb; id_mem_r_en = ld; id_dest = d;
        id_src = {4'd0, s1, s0}; id_src_used = used;
    endtask

    // present an instruction and hold it while it stalls; returns observed stall cycles
    task automatic run_consumer(input logic [3:0] s0, input logic [3:0] s1, input logic [2:0] used,
                                input int frz_cycles, output int n);
        int g = 0;
        n = 0;
        set_inst(1'b1, 1'b1, 1'b0, 4'd4, s0, s1, used);
        do begin
            freeze = (g < frz_cycles);
            step();
            n += int'(last_h);
            g++;
        end while (last_h && g < 12);
        freeze = 1'b0;
        if (g >= 12) chk("stall_bound", 32'(g), 32'd11);
    endtask

    task automatic drain();
        set_inst(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 3'b000);
        repeat (DEPTH + 1) step();
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("hazard", 32'(hazard), 32'(e.h));
            chk("hazard_cnt4_inst", 32'(hazard4), 32'(e.h));
            chk("stall_cnt", 32'(stall_cnt), 32'(e.c));
            chk("stall_cnt_sat4", 32'(stall_cnt4), 32'(e.c4));
        end
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) step();
        chk("reset_cnt", 32'(stall_cnt), 32'd0);

        set_inst(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 3'b000);
        step();
        run_consumer(4'd2, 4'd1, 3'b011, 0, n);
        chk("load_use_stall", 32'(n), FWD ? 32'd1 : 32'd2);
        drain();

        set_inst(1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 4'd0, 3'b000);
        step();
        run_consumer(4'd2, 4'd2, 3'b011, 0, n);
        chk("alu_use_stall", 32'(n), FWD ? 32'd0 : 32'd2);
        drain();

        set_inst(1'b1, 1'b1, 1'b1, 4'd2, 4'd0, 4'd0, 3'b000);
        step();
        run_consumer(4'd2, 4'd1, 3'b011, 3, n);
        chk("freeze_stall", 32'(n), FWD ? 32'd4 : 32'd5);
        drain();

        set_inst(1'b1, 1'b1, 1'b1, 4'd5, 4'd0, 4'd0, 3'b000);
        step();
        run_consumer(4'd5, 4'd5, 3'b100, 0, n);
        chk("unused_src", 32'(n), 32'd0);
        drain();

        set_inst(1'b1, 1'b1, 1'b1, 4'd6, 4'd0, 4'd0, 3'b000);
        step();
        flush = 1'b1;
        set_inst(1'b1, 1'b1, 1'b0, 4'd7, 4'd6, 4'd0, 3'b001);
        step();
        flush = 1'b0;
        set_inst(1'b1, 1'b1, 1'b0, 4'd8, 4'd7, 4'd0, 3'b001);
        step();
        chk("flush_bubble", 32'(last_h), 32'd0);
        drain();

        rst = 1'b1; step(); rst = 1'b0;
        for (int r = 0; r < 20; r++) begin
            set_inst(1'b1, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 3'b000);
            step();
            run_consumer(4'd1, 4'd3, 3'b011, 0, n);
        end
        chk("sat4", 32'(stall_cnt4), 32'd15);

        set_inst(1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 4'd0, 3'b000);
        step();
        set_inst(1'b1, 1'b1, 1'b0, 4'd4, 4'd9, 4'd0, 3'b001);
        rst = 1'b1;
        step();
        chk("midstall_reset_h", 32'(last_h), 32'd1);
        rst = 1'b0;
        step();
        chk("post_reset_h", 32'(last_h), 32'd0);
        chk("post_reset_cnt", 32'(stall_cnt), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            set_inst($urandom_range(0, 99) < 85, 1'($urandom), 1'($urandom),
                     4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                     3'($urandom));
            id_src[11:8] = 4'($urandom_range(0, 3));
            flush = $urandom_range(0, 99) < 10;
            freeze = $urandom_range(0, 99) < 15;
            rst = $urandom_range(0, 999) < 2;
            step();
        end
        rst = 1'b0; freeze = 1'b0; flush = 1'b0;
        drain();
        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
